// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemGnt,
    input  imemRvalid,
    input  imemRdata
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemGnt,
    output imemRvalid,
    output imemRdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, a small {pc, inst}
// queue toward decode, and redirect handling that discards stale responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirectPC,
  fetch_unit_if.master imem,
  output logic [31:0]  pcP,
  output logic [31:0]  pcN,
  output logic [31:0]  instOut,
  output logic         instValid
);
  localparam int         PTR_W   = (DEPTH > 2) ? 2 : 1;
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                 state_reg, state_next;
  logic [31:0]            fetch_pc_reg;
  logic [31:0]            req_pc_reg;
  logic [2:0]             cnt_reg;
  logic [2:0]             occ_next;
  logic [PTR_W-1:0]       head_reg, tail_reg;
  logic [DEPTH-1:0][31:0] pc_q, inst_q;
  logic                   push, pop, req, accept;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // A redirect that lands together with the live response consumes it, so there
  // is nothing left to drop and the FSM goes straight back to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = WAIT;
      WAIT: begin
        if (redirect)               state_next = imem.imemRvalid ? IDLE : DROP;
        else if (imem.imemRvalid)   state_next = accept ? WAIT : IDLE;
      end
      DROP: if (imem.imemRvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    push     = (state_reg == WAIT) && imem.imemRvalid && !redirect;
    pop      = instValid && !stall && !redirect;
    occ_next = cnt_reg + 3'(push) - 3'(pop);
    req      = !rst && !redirect && (occ_next < DEPTH_C) &&
               ((state_reg == IDLE) || ((state_reg == WAIT) && imem.imemRvalid));
    accept   = req && imem.imemGnt;
  end

  assign imem.imemReq  = req;
  assign imem.imemAddr = fetch_pc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= RESET_PC;
      cnt_reg      <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
    end else begin
      if (redirect)    fetch_pc_reg <= redirectPC & 32'hFFFF_FFFC;
      else if (accept) fetch_pc_reg <= fetch_pc_reg + 32'd4;
      if (accept) req_pc_reg <= fetch_pc_reg;
      if (redirect) begin
        cnt_reg  <= '0;
        head_reg <= '0;
        tail_reg <= '0;
      end else begin
        cnt_reg <= occ_next;
        if (push) tail_reg <= ptr_inc(tail_reg);
        if (pop)  head_reg <= ptr_inc(head_reg);
      end
    end
  end

  // Entries are cleared on reset so the head reads as pc=0 / inst=0 afterwards.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [31:0] pc_reg, inst_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          pc_reg   <= '0;
          inst_reg <= '0;
        end else if (push && (tail_reg == PTR_W'(gi))) begin
          pc_reg   <= req_pc_reg;
          inst_reg <= imem.imemRdata;
        end
      end
      assign pc_q[gi]   = pc_reg;
      assign inst_q[gi] = inst_reg;
    end
  endgenerate

  assign instValid = (cnt_reg != 3'd0);
  assign pcP       = pc_q[head_reg];
  assign instOut   = inst_q[head_reg];
  assign pcN       = pcP + 32'd4;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, which is the first fetch address after reset (bits [1:0] must be 0).
REQ-002 SHALL have parameter DEPTH, default 2, which is the instruction queue entries (legal 2..4).
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port stall, input, 1 bit: decode not accepting; the queue head is held.
REQ-006 SHALL have port redirect, input, 1 bit: a taken branch/jump; restart fetch at redirectPC.
REQ-007 SHALL have port redirectPC, input, 32 bits: redirect target; bits [1:0] are ignored and treated as 0.
REQ-008 SHALL have port imemReq, output, 1 bit: instruction memory request.
REQ-009 SHALL have port imemAddr, output, 32 bits: request address, word-aligned.
REQ-010 SHALL have port imemGnt, input, 1 bit: request accepted when imemReq && imemGnt.
REQ-011 SHALL have port imemRvalid, input, 1 bit: response valid; responses are in order, at least 1 cycle after acceptance.
REQ-012 SHALL have port imemRdata, input, 32 bits: response instruction word.
REQ-013 SHALL have port pcP, output, 32 bits: PC of the instruction at the queue head.
REQ-014 SHALL have port pcN, output, 32 bits: pcP + 4, modulo 2^32.
REQ-015 SHALL have port instOut, output, 32 bits: instruction at the queue head.
REQ-016 SHALL have port instValid, output, 1 bit: the queue is non-empty.

Function
REQ-017 SHALL hold a fetchPC register and a FIFO of DEPTH {pc, inst} entries; at most one memory request outstanding at a time.
REQ-018 SHALL implement the FSM states IDLE (none outstanding), WAIT (outstanding, live) and DROP (outstanding, stale).
REQ-019 SHALL make these transitions: IDLE->WAIT on acceptance; WAIT->IDLE on imemRvalid with no new acceptance; WAIT->WAIT on imemRvalid plus a new acceptance in the same cycle; WAIT->DROP on redirect; DROP->IDLE on imemRvalid; rvalid in IDLE is ignored.
REQ-020 SHALL define push = (state==WAIT && imemRvalid && !redirect) and pop = (instValid && !stall && !redirect).
REQ-021 SHALL drive imemReq = !redirect && (state==IDLE || (state==WAIT && imemRvalid)) && (occupancy + push - pop) < DEPTH; imemAddr = fetchPC.
REQ-022 SHALL hold imemReq and imemAddr stable while imemGnt is low until acceptance or redirect; on acceptance fetchPC += 4, wrapping 32'hFFFFFFFC->32'h00000000.
REQ-023 SHALL, on push, write {address of the outstanding request, imemRdata} at the tail; the entry becomes visible on instValid the next cycle (no bypass; rvalid->instValid latency 1 cycle).
REQ-024 SHALL hold pcP, pcN and instOut stable while instValid && stall.
REQ-025 SHALL, when push and pop occur in the same cycle, leave occupancy unchanged; push is never issued when the queue is full (guaranteed by REQ-021).
REQ-026 SHALL, on redirect (priority over stall and push): flush the queue (instValid=0 next cycle), set fetchPC = {redirectPC[31:2],2'b00}, set imemReq=0 that cycle, and move WAIT->DROP; a response arriving in the same cycle as redirect is dropped.
REQ-027 SHALL, in DROP, issue no request until the stale response has returned; the first request at redirectPC goes out in the cycle after DROP->IDLE.
REQ-028 SHALL, on a redirect in DROP or IDLE, simply update fetchPC; a repeated redirect takes the last target.
REQ-029 SHALL keep pcN combinational from pcP; all other outputs are registered or a function of state/registers, except imemReq, which depends on imemRvalid.

Reset
REQ-030 SHALL, while rst=1: set state=IDLE, empty the queue, fetchPC=RESET_PC, imemReq=0, imemAddr=RESET_PC, instValid=0, pcP=0, pcN=4, instOut=0.
REQ-031 SHALL, on reset mid-request, abandon the outstanding request; a later imemRvalid is ignored in IDLE (the memory is reset alongside).
REQ-032 SHALL make the first request the cycle after rst deasserts, with imemAddr=RESET_PC.

Verification
REQ-033 SHALL verify reset then streaming: gnt=1, rvalid 1 cycle later, stall=0 -> instValid pcP sequence 0x0,0x4,0x8, one instruction per cycle in steady state, pcN=pcP+4.
REQ-034 SHALL verify stall with a full queue: stall=1 for 5 cycles with DEPTH=2 -> 2 entries held, imemReq=0, pcP/instOut stable; on release, in-order drain with no loss.
REQ-035 SHALL verify a redirect during WAIT: redirect to 0x100 while 0x8 is outstanding -> 0x8 response dropped, queue flushed, next imemAddr=0x100, first instValid shows pcP=0x100.
REQ-036 SHALL verify a redirect coinciding with rvalid, plus redirectPC=0x203 -> response discarded, fetch at 0x200.
REQ-037 SHALL verify wrap: redirect to 0xFFFFFFFC -> pcP=0xFFFFFFFC with pcN=0x0, next fetch 0x0.
REQ-038 SHALL verify backpressure: imemGnt low 3 cycles -> imemReq/imemAddr stable; rst asserted in WAIT -> queue empty and a late rvalid ignored.
